// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB first from an ena_in-qualified bit stream.
// Optional even-parity trailer bit enabled by defining SERIE_PARALELO_PARITY_EN.
module serie_paralelo #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ena_in,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             ena_out,
    output logic             err,
    output logic             busy
);

`ifdef SERIE_PARALELO_PARITY_EN
    localparam int LAST = WIDTH + 1;
`else
    localparam int LAST = WIDTH;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
`ifdef SERIE_PARALELO_PARITY_EN
    logic             par;
`endif

    // cnt is zero whenever no word is in flight, so bit_idx is the 1-based index of the bit at this edge
    logic [CNT_W-1:0] bit_idx;
    logic [WIDTH-1:0] word_shifted;
    logic             last_bit;

    assign bit_idx      = cnt + CNT_W'(1);
    assign word_shifted = {sr[WIDTH-2:0], in};
    assign last_bit     = (bit_idx == CNT_W'(LAST));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            out     <= '0;
            ena_out <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
`ifdef SERIE_PARALELO_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            ena_out <= 1'b0;
            err     <= 1'b0;
            if (ena_in) begin
`ifdef SERIE_PARALELO_PARITY_EN
                par <= (cnt == '0) ? in : (par ^ in);
                // The parity bit is checked but never enters the data register
                if (!last_bit) begin
                    sr <= word_shifted;
                end else if ((par ^ in) == 1'b0) begin
                    out     <= sr;
                    ena_out <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
`else
                sr <= word_shifted;
                if (last_bit) begin
                    out     <= word_shifted;
                    ena_out <= 1'b1;
                end
`endif
                if (last_bit) begin
                    cnt  <= '0;
                    busy <= 1'b0;
                end else begin
                    cnt  <= bit_idx;
                    busy <= 1'b1;
                end
                state <= SHIFT;
            end else begin
                // Dropping ena_in after a completed word (cnt==0) is a normal gap, not an abort
                if (state == SHIFT && cnt != '0) begin
                    err <= 1'b1;
                end
                cnt   <= '0;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule
